// File: rtl/ac_frame_ctrl_pkg.sv
// Shared types and configuration checks for the access-control frame sequencer.
package ac_pkg;

    localparam int CNT_W      = 16;
    localparam int SCALE_LOG2 = 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ac_state_e;

    // A frame is legal when both sides are non-zero and the scaled size still fits a counter.
    function automatic logic cfg_ok(input logic [CNT_W-1:0] w, input logic [CNT_W-1:0] h);
        cfg_ok = (w != '0) && (h != '0) &&
                 (w[CNT_W-1 -: SCALE_LOG2] == '0) && (h[CNT_W-1 -: SCALE_LOG2] == '0);
    endfunction

endpackage

// File: rtl/ac_frame_ctrl_xy_counter.sv
// Raster x/y pixel counter with terminal-count flags, cleared at frame start.
module ac_xy_counter
    import ac_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] xmax,
    input  logic [CNT_W-1:0] ymax,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             x_last,
    output logic             frame_last
);

    assign x_last     = (x == xmax);
    assign frame_last = x_last && (y == ymax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x_last) begin
                x <= '0;
                y <= (y == ymax) ? '0 : y + CNT_W'(1);
            end else begin
                x <= x + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ac_frame_ctrl.sv
// Frame sequencer: admits W*H input pixels, counts SCALE*W x SCALE*H output pixels, flags done.
//  state | meaning
//  IDLE  | waiting for an accepted cfg_start
//  RUN   | input and output streams open
//  DRAIN | input closed, output still flowing
//  DONE  | single cycle, frame complete
module ac_frame_ctrl
    import ac_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int SCALE = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_height,
    input  logic             cfg_int_clr,
    output logic             stat_busy,
    output logic             stat_err,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic             us_in_valid,
    input  logic             us_in_ready,
    input  logic             us_out_valid,
    output logic             us_out_ready,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tuser,
    output logic             m_tlast,
    output logic             interrupt_updone
);

    localparam int SL2 = $clog2(SCALE);

    ac_state_e        state, state_nx;
    logic [CNT_W-1:0] in_xmax, in_ymax, out_xmax, out_ymax;
    logic [CNT_W-1:0] in_x_unused, in_y_unused, out_x, out_y;
    logic             in_x_last, in_frame_last, out_x_last, out_frame_last;
    logic             in_en, out_en, in_beat, out_beat;
    logic             cfg_good, start_ok, start_bad, out_done, out_end;

    assign cfg_good  = cfg_ok(cfg_width, cfg_height);
    assign start_ok  = (state == IDLE) && cfg_start && cfg_good;
    assign start_bad = (state == IDLE) && cfg_start && !cfg_good;

    assign s_tready     = us_in_ready & in_en;
    assign us_in_valid  = s_tvalid & in_en;
    assign in_beat      = s_tvalid & s_tready;
    assign us_out_ready = m_tready & out_en;
    assign m_tvalid     = us_out_valid & out_en;
    assign out_beat     = m_tvalid & m_tready;
    assign out_end      = out_beat & out_frame_last;
    assign m_tuser      = m_tvalid & (out_x == '0) & (out_y == '0);
    assign m_tlast      = m_tvalid & out_x_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = RUN;
            RUN:     if (in_beat && in_frame_last) state_nx = (out_done || out_end) ? DONE : DRAIN;
            DRAIN:   if (out_end) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Output side closes itself once its count completes, even if input is still running.
    always_comb begin
        in_en     = (state == RUN);
        out_en    = ((state == RUN) || (state == DRAIN)) && !out_done;
        stat_busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_xmax  <= '0;
            in_ymax  <= '0;
            out_xmax <= '0;
            out_ymax <= '0;
        end else if (start_ok) begin
            in_xmax  <= cfg_width - CNT_W'(1);
            in_ymax  <= cfg_height - CNT_W'(1);
            out_xmax <= (cfg_width << SL2) - CNT_W'(1);
            out_ymax <= (cfg_height << SL2) - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_done         <= 1'b0;
            stat_err         <= 1'b0;
            interrupt_updone <= 1'b0;
        end else begin
            if (start_ok)     out_done <= 1'b0;
            else if (out_end) out_done <= 1'b1;

            if (start_bad)                             stat_err <= 1'b1;
            else if (start_ok)                         stat_err <= 1'b0;
            else if (in_beat && (s_tlast != in_x_last)) stat_err <= 1'b1;

            // Holding the set term through DONE lets it win over a coincident clear.
            if ((state_nx == DONE) || (state == DONE)) interrupt_updone <= 1'b1;
            else if (start_ok || cfg_int_clr)         interrupt_updone <= 1'b0;
        end
    end

    ac_xy_counter #(.CNT_W(CNT_W)) u_in_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .inc        (in_beat),
        .xmax       (in_xmax),
        .ymax       (in_ymax),
        .x          (in_x_unused),
        .y          (in_y_unused),
        .x_last     (in_x_last),
        .frame_last (in_frame_last)
    );

    ac_xy_counter #(.CNT_W(CNT_W)) u_out_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .inc        (out_beat),
        .xmax       (out_xmax),
        .ymax       (out_ymax),
        .x          (out_x),
        .y          (out_y),
        .x_last     (out_x_last),
        .frame_last (out_frame_last)
    );

endmodule

// File: tb/tb_ac_frame_ctrl.sv
// Directed bench for ac_frame_ctrl: W=4, H=2, SCALE=4 frames with a credit-based upsampler model.
module tb_ac_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0, cfg_int_clr = 1'b0;
    logic [15:0] cfg_width = '0, cfg_height = '0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, us_in_ready = 1'b0;
    logic        us_out_valid = 1'b0, m_tready = 1'b0;
    logic        stat_busy, stat_err, s_tready, us_in_valid, us_out_ready;
    logic        m_tvalid, m_tuser, m_tlast, interrupt_updone;

    int errors = 0, checks = 0, frame_id = 0;
    int in_cnt, out_cnt, user_cnt, user_bad, last_bad, hold_viol, cyc, last_beat_cyc, irq_rise_cyc;
    logic bp_en = 1'b0;
    logic prev_irq = 1'b0, prev_mv = 1'b0, prev_mr = 1'b0, prev_uv = 1'b0, prev_ur = 1'b0, prev_rst = 1'b0;

    ac_frame_ctrl #(.CNT_W(16), .SCALE(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_width(cfg_width),
        .cfg_height(cfg_height), .cfg_int_clr(cfg_int_clr), .stat_busy(stat_busy),
        .stat_err(stat_err), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .us_in_valid(us_in_valid), .us_in_ready(us_in_ready), .us_out_valid(us_out_valid),
        .us_out_ready(us_out_ready), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tuser(m_tuser), .m_tlast(m_tlast), .interrupt_updone(interrupt_updone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL [frame %0d] %s: observed=%0h expected=%0h", frame_id, tag, obs, exp);
        end
    endtask

    // Each upsampled input pixel yields 16 output pixels; output never outruns accepted input.
    initial forever begin
        @(posedge clk); #1;
        us_out_valid = (out_cnt < in_cnt * 16);
        if (bp_en) begin
            m_tready    = 1'($urandom_range(0, 1));
            us_in_ready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (s_tvalid && s_tready) in_cnt++;
            if (m_tvalid && m_tready) begin
                if (m_tuser) begin
                    user_cnt++;
                    if (out_cnt != 0) user_bad++;
                end
                if (m_tlast !== ((out_cnt % 16) == 15)) last_bad++;
                out_cnt++;
                if (out_cnt == 128) last_beat_cyc = cyc;
            end
            if (interrupt_updone && !prev_irq && irq_rise_cyc < 0) irq_rise_cyc = cyc;
            if (prev_rst && prev_mv && !prev_mr && !m_tvalid) hold_viol++;
            if (prev_rst && prev_uv && !prev_ur && !us_in_valid) hold_viol++;
        end
        prev_irq = interrupt_updone;
        prev_mv  = m_tvalid;
        prev_mr  = m_tready;
        prev_uv  = us_in_valid;
        prev_ur  = us_in_ready;
        prev_rst = rst_n;
    end

    task automatic clear_counts();
        in_cnt = 0; out_cnt = 0; user_cnt = 0; user_bad = 0; last_bad = 0;
        hold_viol = 0; last_beat_cyc = -100; irq_rise_cyc = -1;
    endtask

    task automatic pulse_start(input logic [15:0] w, input logic [15:0] h);
        cfg_width = w; cfg_height = h; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic feed(input int n, input int bad_idx);
        for (int i = 0; i < n; i++) begin
            int t;
            s_tvalid = 1'b1;
            s_tlast  = ((i % 4) == 3) || (i == bad_idx);
            t = 0;
            @(negedge clk);
            while (!s_tready && t < 500) begin
                @(negedge clk);
                t++;
            end
            chk("feed_timeout", (t < 500), 1);
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic run_frame(input logic bp, input int bad_idx, input logic mid_start,
                             input logic clr_done, input logic exp_err);
        frame_id++;
        clear_counts();
        bp_en = bp;
        if (!bp) begin
            m_tready = 1'b1; us_in_ready = 1'b1;
        end
        pulse_start(16'd4, 16'd2);
        chk("busy_after_start", stat_busy, 1);
        chk("err_cleared_by_start", stat_err, 0);
        chk("irq_cleared_by_start", interrupt_updone, 0);
        fork
            begin
                feed(8, bad_idx);
                @(negedge clk);
                chk("in_beats", in_cnt, 8);
                chk("s_tready_closed", s_tready, 0);
            end
            begin
                if (mid_start) begin
                    repeat (2) @(posedge clk);
                    #1;
                    cfg_start = 1'b1; cfg_width = 16'd0;
                    @(posedge clk); #1;
                    cfg_start = 1'b0; cfg_width = 16'd4;
                    @(negedge clk);
                    chk("busy_start_ignored", stat_busy, 1);
                    chk("err_start_ignored", stat_err, 0);
                end
            end
            begin
                int t;
                t = 0;
                while (!interrupt_updone && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
                chk("irq_timeout", (t < 3000), 1);
                if (clr_done) begin
                    cfg_int_clr = 1'b1;
                    @(posedge clk); #1;
                    cfg_int_clr = 1'b0;
                    @(negedge clk);
                    chk("irq_set_wins", interrupt_updone, 1);
                end
            end
        join
        bp_en = 1'b0;
        m_tready = 1'b1; us_in_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_beats", out_cnt, 128);
        chk("tuser_count", user_cnt, 1);
        chk("tuser_position", user_bad, 0);
        chk("tlast_position", last_bad, 0);
        chk("irq_latency", irq_rise_cyc, last_beat_cyc + 1);
        chk("valid_hold", hold_viol, 0);
        chk("busy_after_frame", stat_busy, 0);
        chk("err_after_frame", stat_err, exp_err);
    endtask

    initial begin
        clear_counts();
        cyc = 0;
        s_tvalid = 1'b1; m_tready = 1'b1; us_in_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", stat_busy, 0);
        chk("rst_err", stat_err, 0);
        chk("rst_irq", interrupt_updone, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_us_in_valid", us_in_valid, 0);
        chk("rst_us_out_ready", us_out_ready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; s_tvalid = 1'b0;
        @(posedge clk); #1;

        run_frame(1'b0, -1, 1'b0, 1'b0, 1'b0);

        pulse_start(16'd0, 16'd2);
        @(negedge clk);
        chk("w0_err", stat_err, 1);
        chk("w0_busy", stat_busy, 0);
        @(posedge clk); #1;
        pulse_start(16'h4000, 16'd2);
        @(negedge clk);
        chk("ovf_err", stat_err, 1);
        chk("ovf_busy", stat_busy, 0);
        @(posedge clk); #1;
        run_frame(1'b1, -1, 1'b0, 1'b0, 1'b0);

        run_frame(1'b0, 2, 1'b0, 1'b0, 1'b1);

        run_frame(1'b0, -1, 1'b1, 1'b1, 1'b0);
        chk("irq_held", interrupt_updone, 1);
        cfg_int_clr = 1'b1;
        @(posedge clk); #1;
        cfg_int_clr = 1'b0;
        @(negedge clk);
        chk("irq_cleared", interrupt_updone, 0);
        @(posedge clk); #1;

        frame_id++;
        clear_counts();
        pulse_start(16'd4, 16'd2);
        feed(5, -1);
        s_tvalid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", stat_busy, 0);
        chk("midrst_s_tready", s_tready, 0);
        chk("midrst_us_in_valid", us_in_valid, 0);
        chk("midrst_us_out_ready", us_out_ready, 0);
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_irq", interrupt_updone, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; s_tvalid = 1'b0;
        @(posedge clk); #1;
        run_frame(1'b0, -1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
